sram_access_ctrl: RTL



---
 rtl/sram_ctrl_pkg.sv | 25 ++
 rtl/sram_row_dec.sv | 33 +++
 rtl/sram_access_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and geometry defaults for the SRAM access sequencer.
// Imported by the top-level controller and its row decoder.
package sram_ctrl_pkg;

  localparam int DefAddrW  = 7;
  localparam int DefDataW  = 32;
  localparam int DefPreCyc = 1;
  localparam int DefWlCyc  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StAct,
    StSense,
    StWr
  } sram_state_e;

  // Wide enough to hold max(pre_cyc, wl_cyc) - 1, never narrower than one bit.
  function automatic int cnt_width(input int pre_cyc, input int wl_cyc);
    int m;
    m = (pre_cyc > wl_cyc) ? pre_cyc : wl_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sram_row_dec.sv
// Registered row decoder: one-hot wordline for the latched address while enabled,
// all-zero otherwise.
module sram_row_dec #(
  parameter int ADDR_W = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [ADDR_W-1:0]      addr_i,
  output logic [2**ADDR_W-1:0]   wl_o
);

  localparam int Rows = 2**ADDR_W;

  logic [Rows-1:0] dec;
  logic [Rows-1:0] wl_q;

  always_comb begin
    dec         = '0;
    dec[addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wl_q <= '0;
    end else begin
      wl_q <= en_i ? dec : '0;
    end
  end

  assign wl_o = wl_q;

endmodule

// File: rtl/sram_access_ctrl.sv
// Access sequencer for a 6T SRAM array: turns a single read/write request into the
// precharge -> wordline -> sense/write sequence, with every array control registered.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DefAddrW,
  parameter int DATA_W  = DefDataW,
  parameter int PRE_CYC = DefPreCyc,
  parameter int WL_CYC  = DefWlCyc
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  wr_done,
  output logic                  precharge,
  output logic [2**ADDR_W-1:0]  wl,
  output logic                  write_en,
  output logic                  bl_drv_en,
  output logic [DATA_W-1:0]     bl_drv_data,
  output logic                  sense_en,
  input  logic [DATA_W-1:0]     sense_data
);

  localparam int CntW = cnt_width(PRE_CYC, WL_CYC);
  localparam logic [CntW-1:0] PreLoad = CntW'(PRE_CYC - 1);
  localparam logic [CntW-1:0] WlLoad  = CntW'(WL_CYC - 1);

  if (PRE_CYC < 1) begin : g_bad_pre_cyc
    $error("sram_access_ctrl: PRE_CYC must be at least 1");
  end
  if (WL_CYC < 1) begin : g_bad_wl_cyc
    $error("sram_access_ctrl: WL_CYC must be at least 1");
  end

  sram_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cnt_zero;
  logic              accept;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic              precharge_q, precharge_d;
  logic              write_en_q, write_en_d;
  logic              sense_en_q, sense_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              wr_done_q, wr_done_d;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] bl_drv_data_q;
  logic              drv_load;
  logic              rdata_capture;
  logic              wl_en;

  assign cnt_zero = (cnt_q == '0);
  assign accept   = (state_q == StIdle) && req_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StPre;
          cnt_d   = PreLoad;
        end
      end
      StPre: begin
        if (cnt_zero) begin
          state_d = we_q ? StWr : StAct;
          cnt_d   = WlLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StAct: begin
        if (cnt_zero) begin
          state_d = StSense;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSense: begin
        state_d = StIdle;
      end
      StWr: begin
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: array controls decode the upcoming state so they register cleanly.
  always_comb begin
    precharge_d   = (state_d == StPre);
    write_en_d    = (state_d == StWr);
    sense_en_d    = (state_d == StSense);
    wl_en         = (state_d == StAct) || (state_d == StSense) || (state_d == StWr);
    rsp_valid_d   = (state_q == StSense);
    wr_done_d     = (state_q == StWr) && cnt_zero;
    rdata_capture = (state_q == StSense);
    drv_load      = (state_d == StWr) && (state_q != StWr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      precharge_q   <= 1'b0;
      write_en_q    <= 1'b0;
      sense_en_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      wr_done_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      bl_drv_data_q <= '0;
    end else begin
      precharge_q <= precharge_d;
      write_en_q  <= write_en_d;
      sense_en_q  <= sense_en_d;
      rsp_valid_q <= rsp_valid_d;
      wr_done_q   <= wr_done_d;
      if (rdata_capture) begin
        rsp_rdata_q <= sense_data;
      end
      // Driver data only changes on WR entry; bl_drv_en qualifies it.
      if (drv_load) begin
        bl_drv_data_q <= wdata_q;
      end
    end
  end

  sram_row_dec #(
    .ADDR_W (ADDR_W)
  ) u_row_dec (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (wl_en),
    .addr_i (addr_q),
    .wl_o   (wl)
  );

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign wr_done     = wr_done_q;
  assign precharge   = precharge_q;
  assign write_en    = write_en_q;
  assign bl_drv_en   = write_en_q;
  assign bl_drv_data = bl_drv_data_q;
  assign sense_en    = sense_en_q;

  a_wl_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(wl));
  a_we_sense: assert property (@(posedge clk) disable iff (rst) !(write_en && sense_en));
  a_pre_wl: assert property (@(posedge clk) disable iff (rst) !(precharge && (|wl)));
  a_wl_switch: assert property (@(posedge clk) disable iff (rst)
                                ((|wl) && (|$past(wl))) |-> (wl == $past(wl)));

endmodule
